riscv_bif_arbiter: RTL and testbench
====================================

// Module: riscv_bif_arbiter
// PURPOSE
//  Shares the single external memory bus between the fetch stage (inst_*) and the load/store path (data_*).
//  One outstanding transaction at a time; round-robin grant when both requesters request in the same cycle.
//  Routes mem_ack/mem_rdata back to the owning requester.
//  A watchdog terminates unanswered transactions with an error ack so the pipeline cannot hang.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width; byte enables are DATA_W/8 bits
//  TIMEOUT_CYC  16  cycles mem_req may wait for mem_ack; 0 disables the watchdog
//  TMO_W        5   watchdog counter width; must satisfy 2**TMO_W > TIMEOUT_CYC
// PORTS
//  clk          in   1         clock
//  rstn         in   1         synchronous active-low reset
//  inst_req     in   1         fetch request; held with its fields until inst_ack
//  inst_addr    in   ADDR_W    fetch address (read only)
//  inst_ack     out  1         1-cycle pulse: fetch complete
//  inst_rdata   out  DATA_W    fetch data; valid only with inst_ack
//  data_req     in   1         load/store request; held with its fields until data_ack
//  data_addr    in   ADDR_W    load/store address
//  data_we      in   1         1 = write, 0 = read
//  data_be      in   DATA_W/8  byte enables
//  data_wdata   in   DATA_W    store data
//  data_ack     out  1         1-cycle pulse: load/store complete
//  data_rdata   out  DATA_W    load data; valid only with data_ack
//  bus_err      out  1         qualifies inst_ack/data_ack; 1 = watchdog timeout
//  mem_req      out  1         registered bus request
//  mem_addr     out  ADDR_W    registered bus address
//  mem_we       out  1         registered bus write enable
//  mem_be       out  DATA_W/8  registered bus byte enables
//  mem_wdata    out  DATA_W    registered bus write data
//  mem_ack      in   1         bus completion; sampled only while mem_req=1
//  mem_rdata    in   DATA_W    bus read data; valid with mem_ack
//  arb_busy     out  1         1 while a transaction is owned (state != IDLE)
// BEHAVIOUR
//  Reset: when rstn=0 at a clk edge, all outputs go to 0 after that edge, FSM=IDLE, last_gnt=INST, counter=0.
//    Applies mid-transaction: the transaction is abandoned and no ack is issued.
//  FSM: IDLE, OWN_I, OWN_D.
//  IDLE:
//    - Only inst_req -> OWN_I. Only data_req -> OWN_D.
//    - Both -> grant the side that is not last_gnt (data wins first after reset).
//    - On grant: update last_gnt; register the granted fields into mem_*.
//      For a fetch, mem_we=0, mem_be=all 1s, mem_wdata=0.
//    - Latency: req sampled in cycle N -> mem_req=1 in cycle N+1.
//  OWN_x:
//    - mem_req and mem_* held stable until mem_ack=1 or timeout.
//    - mem_ack=1: x_ack=1 combinationally in the same cycle; x_rdata=mem_rdata; bus_err=0.
//      Next edge: mem_req=0, counter=0, FSM=IDLE.
//    - The non-owner's ack is always 0; its request stays pending.
//  Watchdog (TIMEOUT_CYC>0):
//    - Counter counts cycles with mem_req=1 && mem_ack=0.
//    - When counter==TIMEOUT_CYC: x_ack=1, bus_err=1, x_rdata=0. Next edge: mem_req=0, FSM=IDLE.
//    - mem_ack=1 in that same cycle has priority: normal ack, bus_err=0.
//  mem_ack while IDLE (late or spurious) is ignored; no ack is routed.
//  Throughput: at most one transaction per 2 cycles (grant cycle plus ack cycle).
//  Fairness: with both requests held continuously, grants alternate D, I, D, I.
//  Requester rule: a requester must not deassert or change req fields before its ack.
//    The arbiter does not check this.
//  No combinational path from inst_req/data_req to any output; acks depend only on mem_ack and FSM/counter state.
// TESTING
//  1 Reset: hold rstn=0 for 2 cycles with both reqs=1 -> all outputs 0, arb_busy=0.
//  2 Data read: data_req, addr=0x100; mem_ack 2 cycles after mem_req, rdata=0xDEADBEEF
//      -> mem_req rises 1 cycle after req; data_ack pulses 1 cycle with 0xDEADBEEF; inst_ack=0.
//  3 Contention: inst_req and data_req held from the first cycle after reset, each mem_ack 1 cycle after mem_req
//      -> grant order D,I,D,I; mem_addr alternates between the two addresses.
//  4 Byte store: data_we=1, be=4'b0010, wdata=0x0000AB00, addr=0x204
//      -> mem_we=1, mem_be=4'b0010, mem_wdata=0x0000AB00; data_ack pulses on mem_ack.
//  5 Timeout (TIMEOUT_CYC=4): inst_req, mem_ack never asserted
//      -> inst_ack=1 with bus_err=1 and inst_rdata=0 after 4 waiting cycles; mem_req=0 next cycle.
//      A later mem_ack is ignored. Repeat with mem_ack arriving in the timeout cycle -> bus_err=0.
//  6 Reset mid-transaction: rstn=0 while OWN_D with mem_ack pending
//      -> next cycle mem_req=0, no data_ack; after release, a fresh data_req completes normally.

Source files
------------

// File: rtl/riscv_bif_arbiter.sv
// Fetch / load-store bus arbiter: one outstanding transaction, round-robin on contention,
// acks routed back to the owner, and a watchdog that error-acks a silent bus.
module riscv_bif_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int TMO_W       = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_ack,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_we,
    input  logic [DATA_W/8-1:0] data_be,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_ack,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_err,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy
);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
    localparam bit               TMO_EN  = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] { IDLE, OWN_I, OWN_D } state_t;

    state_t           state;
    logic             last_gnt_d;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             xfer_ok;
    logic             done;

    // mem_req is only set while owned, so these terms never fire in IDLE.
    assign tmo_hit = TMO_EN && mem_req && (tmo_cnt == TMO_LIM);
    assign xfer_ok = mem_req && mem_ack;
    assign done    = xfer_ok || tmo_hit;

    assign inst_ack   = (state == OWN_I) && done;
    assign data_ack   = (state == OWN_D) && done;
    assign bus_err    = tmo_hit && !mem_ack;
    assign inst_rdata = ((state == OWN_I) && xfer_ok) ? mem_rdata : '0;
    assign data_rdata = ((state == OWN_D) && xfer_ok) ? mem_rdata : '0;
    assign arb_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            last_gnt_d <= 1'b0;
            tmo_cnt    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    // On contention the side that did not win last time gets the bus.
                    if (data_req && (!inst_req || !last_gnt_d)) begin
                        state      <= OWN_D;
                        last_gnt_d <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_addr   <= data_addr;
                        mem_we     <= data_we;
                        mem_be     <= data_be;
                        mem_wdata  <= data_wdata;
                    end else if (inst_req) begin
                        state      <= OWN_I;
                        last_gnt_d <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_addr   <= inst_addr;
                        mem_we     <= 1'b0;
                        mem_be     <= '1;
                        mem_wdata  <= '0;
                    end
                end
                OWN_I, OWN_D: begin
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_bif_arbiter.sv
// Self-checking bench for riscv_bif_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_riscv_bif_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int TW  = 3;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            inst_req = 1'b0;
    logic [AW-1:0]   inst_addr = '0;
    logic            inst_ack;
    logic [DW-1:0]   inst_rdata;
    logic            data_req = 1'b0;
    logic [AW-1:0]   data_addr = '0;
    logic            data_we = 1'b0;
    logic [DW/8-1:0] data_be = '0;
    logic [DW-1:0]   data_wdata = '0;
    logic            data_ack;
    logic [DW-1:0]   data_rdata;
    logic            bus_err;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
    logic            arb_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_bif_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO), .TMO_W(TW)) dut (
        .clk(clk), .rstn(rstn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .bus_err(bus_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0; inst_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
        data_we = 1'b0; data_be = '0; data_wdata = '0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; inst_req = 1'b1; data_req = 1'b1;
        inst_addr = 32'h0000_0040; data_addr = 32'h0000_0080; data_we = 1'b1; data_be = 4'hf;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, arb_busy, bus_err, inst_ack, data_ack} !== 6'b0)
            $display("FAIL reset_ctrl: got %b exp 000000",
                     {mem_req, mem_we, arb_busy, bus_err, inst_ack, data_ack});
        checks++;
        if ({mem_addr, mem_be, mem_wdata} !== '0)
            $display("FAIL reset_bus: got %h/%h/%h exp 0", mem_addr, mem_be, mem_wdata);
        checks++;
        if ({inst_rdata, data_rdata} !== '0)
            $display("FAIL reset_rdata: got %h/%h exp 0", inst_rdata, data_rdata);
        errors += ((({mem_req, mem_we, arb_busy, bus_err, inst_ack, data_ack} !== 6'b0) ? 1 : 0)
                 + (({mem_addr, mem_be, mem_wdata} !== '0) ? 1 : 0)
                 + (({inst_rdata, data_rdata} !== '0) ? 1 : 0));
    endtask

    task automatic test_data_read();
        do_reset();
        data_req = 1'b1; data_addr = 32'h0000_0100; data_we = 1'b0; data_be = 4'hf;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_no_early_req: got %b exp 0", mem_req); end
        step();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
            errors++; $display("FAIL rd_req: got req=%b we=%b addr=%h exp 1 0 00000100", mem_req, mem_we, mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (data_ack !== 1'b0) begin errors++; $display("FAIL rd_wait_ack: got %b exp 0", data_ack); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({data_ack, inst_ack, bus_err, data_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_ack: got dack=%b iack=%b err=%b rdata=%h exp 1 0 0 deadbeef",
                     data_ack, inst_ack, bus_err, data_rdata);
        end
        step();
        mem_ack = 1'b0; data_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_ack, mem_req, arb_busy} !== 3'b000) begin
            errors++; $display("FAIL rd_release: got %b exp 000", {data_ack, mem_req, arb_busy});
        end
    endtask

    task automatic test_contention();
        int waits;
        logic exp_data;
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_addr = 32'h0000_2000; data_we = 1'b0; data_be = 4'hf;
        for (int g = 0; g < 4; g++) begin
            exp_data = (g % 2 == 0);
            waits = 0;
            @(negedge clk);
            while (mem_req !== 1'b1 && waits < 6) begin
                step();
                waits++;
                @(negedge clk);
            end
            checks++;
            if (waits != 1) begin errors++; $display("FAIL cont_gap g=%0d: got %0d idle cycles exp 1", g, waits); end
            checks++;
            if (mem_addr !== (exp_data ? 32'h0000_2000 : 32'h0000_1000)) begin
                errors++; $display("FAIL cont_order g=%0d: got addr %h exp %h", g, mem_addr,
                                   exp_data ? 32'h0000_2000 : 32'h0000_1000);
            end
            step();
            mem_ack = 1'b1; mem_rdata = 32'h5000 + 32'(g);
            @(negedge clk);
            checks++;
            if ({data_ack, inst_ack} !== {exp_data, !exp_data}) begin
                errors++; $display("FAIL cont_ack g=%0d: got d=%b i=%b exp d=%b i=%b", g, data_ack, inst_ack,
                                   exp_data, !exp_data);
            end
            step();
            mem_ack = 1'b0;
            if (g == 3) begin inst_req = 1'b0; data_req = 1'b0; end
        end
    endtask

    task automatic test_byte_store();
        do_reset();
        data_req = 1'b1; data_addr = 32'h0000_0204; data_we = 1'b1; data_be = 4'b0010;
        data_wdata = 32'h0000_AB00;
        step();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0000_0204}) begin
            errors++; $display("FAIL st_fields: got req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 0010 0000ab00 00000204",
                               mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({data_ack, inst_ack, bus_err} !== 3'b100) begin
            errors++; $display("FAIL st_ack: got %b exp 100", {data_ack, inst_ack, bus_err});
        end
        step();
        mem_ack = 1'b0; data_req = 1'b0; data_we = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h0000_0300; mem_rdata = 32'h1234_5678;
        step();
        @(negedge clk);
        checks++;
        if ({mem_we, mem_be, mem_wdata} !== {1'b0, 4'hf, 32'h0}) begin
            errors++; $display("FAIL fetch_fields: got we=%b be=%b wdata=%h exp 0 1111 0", mem_we, mem_be, mem_wdata);
        end
        for (int w = 0; w < TMO; w++) begin
            if (w > 0) @(negedge clk);
            checks++;
            if ({mem_req, inst_ack} !== 2'b10) begin
                errors++; $display("FAIL tmo_wait w=%0d: got req=%b ack=%b exp 1 0", w, mem_req, inst_ack);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({inst_ack, bus_err, inst_rdata, data_ack} !== {2'b11, 32'h0, 1'b0}) begin
            errors++; $display("FAIL tmo_ack: got ack=%b err=%b rdata=%h dack=%b exp 1 1 0 0",
                               inst_ack, bus_err, inst_rdata, data_ack);
        end
        step();
        inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, arb_busy, inst_ack} !== 3'b000) begin
            errors++; $display("FAIL tmo_release: got %b exp 000", {mem_req, arb_busy, inst_ack});
        end
        step();
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst_ack, data_ack, bus_err, inst_rdata} !== '0) begin
            errors++; $display("FAIL late_ack: got i=%b d=%b err=%b rdata=%h exp 0", inst_ack, data_ack, bus_err, inst_rdata);
        end
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, arb_busy} !== 2'b00) begin
            errors++; $display("FAIL late_ack_idle: got %b exp 00", {mem_req, arb_busy});
        end
        step();
        inst_req = 1'b1; inst_addr = 32'h0000_0304;
        step();
        for (int w = 0; w < TMO; w++) begin
            @(negedge clk);
            checks++;
            if (inst_ack !== 1'b0) begin errors++; $display("FAIL tmo2_wait w=%0d: got %b exp 0", w, inst_ack); end
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({inst_ack, bus_err, inst_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL tmo_race: got ack=%b err=%b rdata=%h exp 1 0 cafef00d", inst_ack, bus_err, inst_rdata);
        end
        step();
        mem_ack = 1'b0; inst_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_req = 1'b1; data_addr = 32'h0000_0400; data_we = 1'b0; data_be = 4'hf;
        step();
        @(negedge clk);
        checks++;
        if ({mem_req, arb_busy} !== 2'b11) begin
            errors++; $display("FAIL mid_owned: got %b exp 11", {mem_req, arb_busy});
        end
        step();
        rstn = 1'b0; data_req = 1'b0;
        step();
        rstn = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        checks++;
        if ({mem_req, data_ack, arb_busy, bus_err} !== 4'b0000) begin
            errors++; $display("FAIL mid_abandon: got %b exp 0000", {mem_req, data_ack, arb_busy, bus_err});
        end
        step();
        mem_ack = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0500;
        step();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0500}) begin
            errors++; $display("FAIL mid_fresh_req: got req=%b addr=%h exp 1 00000500", mem_req, mem_addr);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if ({data_ack, bus_err, data_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL mid_fresh_ack: got ack=%b err=%b rdata=%h exp 1 0 0badf00d", data_ack, bus_err, data_rdata);
        end
        step();
        mem_ack = 1'b0; data_req = 1'b0;
    endtask

    // Transaction-level model: who owns the bus, what they asked for, how long they have waited.
    task automatic test_random();
        int owner = -1;            // -1 none, 0 fetch, 1 load/store
        int waited = 0;
        bit inst_next = 1'b0;      // set when fetch should win the next tie
        bit fin, i_done, d_done;
        logic [AW+1+DW/8+DW-1:0] exp_bus;
        logic [DW-1:0] exp_rd;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!inst_req && $urandom_range(0, 1) == 1) begin
                inst_req = 1'b1; inst_addr = $urandom;
            end
            if (!data_req && $urandom_range(0, 1) == 1) begin
                data_req = 1'b1; data_addr = $urandom; data_we = 1'($urandom_range(0, 1));
                data_be = 4'($urandom_range(0, 15)); data_wdata = $urandom;
            end
            mem_ack = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            fin = (owner >= 0) && (mem_ack || waited == TMO);
            exp_rd = (fin && mem_ack) ? mem_rdata : '0;
            checks++;
            if ({mem_req, arb_busy} !== {2{owner >= 0}}) begin
                errors++; $display("FAIL rnd_busy cyc=%0d: got req=%b busy=%b exp %b", cyc, mem_req, arb_busy, owner >= 0);
            end
            if (owner >= 0) begin
                checks++;
                if ({mem_addr, mem_we, mem_be, mem_wdata} !== exp_bus) begin
                    errors++; $display("FAIL rnd_bus cyc=%0d: got %h exp %h", cyc, {mem_addr, mem_we, mem_be, mem_wdata}, exp_bus);
                end
            end
            checks++;
            if ({inst_ack, data_ack, bus_err} !== {fin && owner == 0, fin && owner == 1, fin && !mem_ack}) begin
                errors++; $display("FAIL rnd_ack cyc=%0d: got i=%b d=%b err=%b exp i=%b d=%b err=%b", cyc,
                                   inst_ack, data_ack, bus_err, fin && owner == 0, fin && owner == 1, fin && !mem_ack);
            end
            checks++;
            if ({inst_rdata, data_rdata} !== {(owner == 0) ? exp_rd : 32'h0, (owner == 1) ? exp_rd : 32'h0}) begin
                errors++; $display("FAIL rnd_rdata cyc=%0d: got i=%h d=%h exp %h owner=%0d", cyc, inst_rdata, data_rdata, exp_rd, owner);
            end
            @(posedge clk);
            i_done = 1'b0; d_done = 1'b0;
            if (owner >= 0) begin
                if (fin) begin
                    i_done = (owner == 0); d_done = (owner == 1);
                    owner = -1; waited = 0;
                end else begin
                    waited++;
                end
            end else if (data_req && (!inst_req || !inst_next)) begin
                owner = 1; inst_next = 1'b1;
                exp_bus = {data_addr, data_we, data_be, data_wdata};
            end else if (inst_req) begin
                owner = 0; inst_next = 1'b0;
                exp_bus = {inst_addr, 1'b0, 4'hf, 32'h0};
            end
            #1;
            if (i_done) inst_req = 1'b0;
            if (d_done) data_req = 1'b0;
        end
        mem_ack = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_contention();
        test_byte_store();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
